// File: rtl/display_source_scheduler_pkg.sv
// Shared constants and types for the display source scheduler:
// source encodings, FSM state encodings and display/digit widths.
package display_source_scheduler_pkg;

  localparam int DISP_W     = 12;  // three BCD-style digits
  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = DISP_W / DIGIT_W;

  localparam logic [1:0] SRC_ENTRY  = 2'd0;
  localparam logic [1:0] SRC_RESULT = 2'd1;
  localparam logic [1:0] SRC_MEM    = 2'd2;

  // State codes deliberately match the source codes they display.
  typedef enum logic [1:0] {
    S_ENTRY  = 2'd0,
    S_RESULT = 2'd1,
    S_MEM    = 2'd2
  } state_t;

  // Map an FSM state to the src_sel code reported on the output.
  function automatic logic [1:0] state_to_src(input state_t s);
    logic [1:0] src;
    case (s)
      S_RESULT: src = SRC_RESULT;
      S_MEM:    src = SRC_MEM;
      default:  src = SRC_ENTRY;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/display_source_scheduler_hold_timer.sv
// hold_timer: loadable down-counter with a zero flag. Load wins over
// decrement; the count saturates at zero instead of wrapping.
module display_source_scheduler_hold_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  // Load, or count down towards zero while enabled.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/display_source_scheduler.sv
// display_source_scheduler: picks which 12-bit source (keypad entry, ALU
// result, memory recall) drives the shared 7-segment decoder input.
// Priority mem_req > result_req > entry_valid; memory recall is shown for
// a fixed dwell of HOLD_CYCLES and then returns to the remembered source.
// Optional feature macro: DISPLAY_OVF_BLINK_EN (blink on overflowed result).
module display_source_scheduler
  import display_source_scheduler_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000000,
  parameter int BLINK_HALF  = 12500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DISP_W-1:0] entry_value,
  input  logic              entry_valid,
  input  logic [DISP_W-1:0] result_value,
  input  logic              result_req,
  input  logic              result_ovf,
  input  logic [DISP_W-1:0] mem_value,
  input  logic              mem_req,
  output logic [DISP_W-1:0] memory,
  output logic [1:0]        src_sel,
  output logic              blank,
  output logic              busy
);

  localparam int DWELL_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(HOLD_CYCLES - 1);

  state_t            state_reg, state_next;
  state_t            ret_reg, ret_next;
  logic [DISP_W-1:0] result_reg, result_next;
  logic [DISP_W-1:0] memory_reg, memory_next;
  logic [1:0]        src_sel_reg;
  logic              busy_reg;
  logic              blank_reg, blank_next;
  logic              dwell_zero;

  // Dwell timer: loaded by every mem_req, counts while the memory view is up.
  display_source_scheduler_hold_timer #(
    .WIDTH (DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .srst       (rst),
    .load       (mem_req),
    .load_value (DWELL_LOAD),
    .en         (state_reg == S_MEM),
    .zero       (dwell_zero)
  );

`ifdef DISPLAY_OVF_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_HALF + 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_HALF - 1);

  logic ovf_reg, ovf_next;
  logic blink_zero;
  logic result_entry;
  logic blink_load;

  // A result view is (re)entered on a state change into S_RESULT or on a
  // fresh result_req while already there.
  assign result_entry = (state_next == S_RESULT) &&
                        ((state_reg != S_RESULT) || result_req);
  assign blink_load   = result_entry ||
                        ((state_reg == S_RESULT) && blink_zero);

  // Blink timer: reloaded on each result entry and at each half-period.
  display_source_scheduler_hold_timer #(
    .WIDTH (BLINK_W)
  ) u_blink_timer (
    .clk        (clk),
    .srst       (rst),
    .load       (blink_load),
    .load_value (BLINK_LOAD),
    .en         (state_reg == S_RESULT),
    .zero       (blink_zero)
  );
`else
  logic unused_ovf;
  localparam int unused_blink_half = BLINK_HALF;
  assign unused_ovf = result_ovf;
`endif

  // Next-state, return-state and captured-value logic.
  always_comb begin
    state_t ret_upd;
    state_next  = state_reg;
    ret_next    = ret_reg;
    result_next = result_reg;
    ret_upd     = ret_reg;
`ifdef DISPLAY_OVF_BLINK_EN
    ovf_next    = ovf_reg;
`endif

    // A result is always captured, even when a memory recall wins the display.
    if (result_req) begin
      result_next = result_value;
`ifdef DISPLAY_OVF_BLINK_EN
      ovf_next    = result_ovf;
`endif
    end

    // Lower-priority requests only steer where a memory view returns to.
    if (result_req) begin
      ret_upd = S_RESULT;
    end else if (entry_valid) begin
      ret_upd = S_ENTRY;
    end else if (state_reg != S_MEM) begin
      ret_upd = state_reg;
    end

    if (mem_req) begin
      state_next = S_MEM;
      ret_next   = ret_upd;
    end else if (state_reg == S_MEM) begin
      ret_next = ret_upd;
      if (dwell_zero) begin
        state_next = ret_upd;
      end
    end else if (result_req) begin
      state_next = S_RESULT;
    end else if (entry_valid) begin
      state_next = S_ENTRY;
    end

    case (state_next)
      S_RESULT: memory_next = result_next;
      S_MEM:    memory_next = mem_req ? mem_value : memory_reg;
      default:  memory_next = entry_value;
    endcase
  end

  // Blank output: blink only while showing an overflowed result.
  always_comb begin
    blank_next = 1'b0;
`ifdef DISPLAY_OVF_BLINK_EN
    if (state_next == S_RESULT) begin
      if (result_entry) begin
        blank_next = ovf_next;
      end else if (ovf_reg && blink_zero) begin
        blank_next = ~blank_reg;
      end else begin
        blank_next = blank_reg;
      end
    end
`endif
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_ENTRY;
      ret_reg     <= S_ENTRY;
      result_reg  <= '0;
      memory_reg  <= '0;
      src_sel_reg <= SRC_ENTRY;
      busy_reg    <= 1'b0;
      blank_reg   <= 1'b0;
`ifdef DISPLAY_OVF_BLINK_EN
      ovf_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      ret_reg     <= ret_next;
      result_reg  <= result_next;
      memory_reg  <= memory_next;
      src_sel_reg <= state_to_src(state_next);
      busy_reg    <= (state_next == S_MEM);
      blank_reg   <= blank_next;
`ifdef DISPLAY_OVF_BLINK_EN
      ovf_reg     <= ovf_next;
`endif
    end
  end

  assign memory  = memory_reg;
  assign src_sel = src_sel_reg;
  assign blank   = blank_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed testbench for display_source_scheduler (HOLD_CYCLES=4,
// BLINK_HALF=2). Expected blank behaviour follows DISPLAY_OVF_BLINK_EN.
module tb_display_source_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] entry_value;
  logic        entry_valid;
  logic [11:0] result_value;
  logic        result_req;
  logic        result_ovf;
  logic [11:0] mem_value;
  logic        mem_req;
  logic [11:0] memory;
  logic [1:0]  src_sel;
  logic        blank;
  logic        busy;

  int vec_count = 0;
  int miscompares = 0;

  display_source_scheduler #(
    .HOLD_CYCLES (4),
    .BLINK_HALF  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .entry_value  (entry_value),
    .entry_valid  (entry_valid),
    .result_value (result_value),
    .result_req   (result_req),
    .result_ovf   (result_ovf),
    .mem_value    (mem_value),
    .mem_req      (mem_req),
    .memory       (memory),
    .src_sel      (src_sel),
    .blank        (blank),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    entry_valid = 1'b0;
    result_req  = 1'b0;
    mem_req     = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [11:0] m, input logic [1:0] s,
                           input logic bl, input logic bz);
    check({tag, ".memory"}, 32'(memory), 32'(m));
    check({tag, ".src_sel"}, 32'(src_sel), 32'(s));
    check({tag, ".blank"}, 32'(blank), 32'(bl));
    check({tag, ".busy"}, 32'(busy), 32'(bz));
  endtask

  logic exp_blink [6];

  initial begin
    rst = 1'b1;
    entry_value = 12'h000; entry_valid = 1'b0;
    result_value = 12'h000; result_req = 1'b0; result_ovf = 1'b0;
    mem_value = 12'h000; mem_req = 1'b0;
    tick(); tick();
    check_all("reset", 12'h000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Entry follows the keypad register with one cycle of latency.
    entry_value = 12'h123;
    tick();
    check_all("entry", 12'h123, 2'd0, 1'b0, 1'b0);

    // Result display, then back to entry on a keypress.
    result_value = 12'h456; result_req = 1'b1;
    tick();
    check_all("result", 12'h456, 2'd1, 1'b0, 1'b0);
    entry_value = 12'h007; entry_valid = 1'b1;
    tick();
    check_all("entry_ret", 12'h007, 2'd0, 1'b0, 1'b0);

    // Back to S_RESULT, then a memory recall with a 4-cycle dwell.
    result_req = 1'b1;
    tick();
    check("result2.src_sel", 32'(src_sel), 32'd1);
    mem_value = 12'h789; mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("dwell1_c%0d", i + 1), 12'h789, 2'd2, 1'b0, 1'b1);
    end
    tick();
    check_all("dwell1_end", 12'h456, 2'd1, 1'b0, 1'b0);

    // All three requests together: memory wins, result becomes return source.
    mem_value = 12'hABC; mem_req = 1'b1;
    result_value = 12'hDEF; result_req = 1'b1;
    entry_value = 12'h111; entry_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("dwell2_c%0d", i + 1), 12'hABC, 2'd2, 1'b0, 1'b1);
    end
    tick();
    check_all("dwell2_end", 12'hDEF, 2'd1, 1'b0, 1'b0);
    entry_value = 12'h222; entry_valid = 1'b1;
    tick();
    check_all("entry_after", 12'h222, 2'd0, 1'b0, 1'b0);

    // Restart the dwell from within the 3rd dwell cycle.
    mem_value = 12'h333; mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all($sformatf("dwell3_c%0d", i + 1), 12'h333, 2'd2, 1'b0, 1'b1);
    end
    mem_value = 12'h444; mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("restart_c%0d", i + 1), 12'h444, 2'd2, 1'b0, 1'b1);
    end
    tick();
    check_all("restart_end", 12'h222, 2'd0, 1'b0, 1'b0);

    // Reset in the middle of a dwell clears everything at once.
    mem_value = 12'h555; mem_req = 1'b1;
    tick();
    tick();
    check("pre_rst.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check_all("mid_rst", 12'h000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_all("post_rst", 12'h222, 2'd0, 1'b0, 1'b0);

    // Overflowed result: blank pattern depends on the optional feature.
`ifdef DISPLAY_OVF_BLINK_EN
    exp_blink = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_blink = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    result_value = 12'h999; result_ovf = 1'b1; result_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_all($sformatf("ovf_c%0d", i + 1), 12'h999, 2'd1, exp_blink[i], 1'b0);
    end
    result_ovf = 1'b0;

    // Leaving S_RESULT forces blank low.
    entry_value = 12'h042; entry_valid = 1'b1;
    tick();
    check_all("ovf_exit", 12'h042, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
- Arbitrates three 12-bit, 3-digit (4 bits per digit) value sources onto the single shared decoder input that drives the three 7-segment displays.
- Sources: live keypad entry, ALU result, memory recall.
- Holds each source on the display according to fixed priority and dwell rules.
- Sits between the calculator datapath/control and the memory-to-segment decoder.

Parameters:
- HOLD_CYCLES, 50000000, dwell of a memory-recall view in clk cycles (1 s at 50 MHz); must be >= 1.
- BLINK_HALF, 12500000, half-period of the overflow blink in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- entry_value  in  12  current keypad entry register.
- entry_valid  in  1  one-cycle pulse: a digit was entered or cleared.
- result_value  in  12  ALU result.
- result_req  in  1  one-cycle pulse: result_value is valid; display it.
- result_ovf  in  1  overflow flag, sampled with result_req.
- mem_value  in  12  stored memory register.
- mem_req  in  1  one-cycle pulse: show memory contents.
- memory  out  12  value to decoder, registered.
- src_sel  out  2  0 = entry, 1 = result, 2 = memory, 3 unused.
- blank  out  1  1 = display should be dark.
- busy  out  1  1 while a timed memory view is active.

Behaviour:
- Single clock, synchronous active-high reset. All outputs are registered.
- Reset values: memory = 0, src_sel = 0, blank = 0, busy = 0; state = S_ENTRY; hold counter = 0; saved ovf = 0. Reset mid-view aborts immediately, with no residual view.
- States:
  - S_ENTRY: memory follows entry_value every cycle (1-cycle latency).
  - S_RESULT: memory = result_value captured at result_req; the display is static.
  - S_MEM: memory = mem_value captured at mem_req; hold counter runs.
- Transition priority in any state, same cycle: mem_req > result_req > entry_valid.
- mem_req from any state:
  - Capture mem_value; go to S_MEM; load counter = HOLD_CYCLES-1; busy = 1.
  - Remember the return state (S_ENTRY or S_RESULT; if already in S_MEM, keep the existing return state).
  - A new mem_req while in S_MEM recaptures the value and restarts the counter.
- result_req (no mem_req):
  - Capture result_value and result_ovf; go to S_RESULT.
  - In S_MEM: update the captured result and set the return state to S_RESULT; stay in S_MEM until dwell expiry.
- entry_valid (no higher request):
  - From S_RESULT: go to S_ENTRY.
  - In S_MEM: set the return state to S_ENTRY only.
  - In S_ENTRY: no state change.
- S_MEM counter:
  - Decrements each cycle.
  - In the cycle it reads 0, the next state is the return state and busy falls.
  - Total dwell is exactly HOLD_CYCLES cycles from the cycle after mem_req.
- src_sel always encodes the state of the registered output. Outputs update 1 cycle after the causing input.
- Counter width is $clog2(HOLD_CYCLES+1). No wrap: the counter never decrements below 0.

Optional Feature:
- Macro: DISPLAY_OVF_BLINK_EN.
- Defined:
  - In S_RESULT with saved ovf = 1, blank toggles every BLINK_HALF cycles, starting at 1 on the cycle S_RESULT is entered.
  - Blank is forced 0 in other states.
  - The blink counter resets on every state entry.
- Undefined: blank is constant 0; ovf is not stored; no blink counter is synthesized.

Decomposition:
- Shared package/header holds:
  - source encodings SRC_ENTRY = 2'd0, SRC_RESULT = 2'd1, SRC_MEM = 2'd2;
  - state encodings;
  - the 12-bit display value width and 4-bit digit width constants.
- One natural sub-module: hold_timer, a loadable down-counter with a zero flag. Reused for dwell and blink.

Test Plan (HOLD_CYCLES = 4, BLINK_HALF = 2):
- Reset, then drive entry_value = 12'h123 -> next cycle memory = 12'h123, src_sel = 0, blank = 0, busy = 0.
- result_req with result_value = 12'h456 -> memory = 12'h456, src_sel = 1. Then entry_valid with entry_value = 12'h007 -> memory = 12'h007, src_sel = 0.
- From S_RESULT, mem_req with mem_value = 12'h789 -> memory = 12'h789, busy = 1 for exactly 4 cycles, then src_sel = 1 with memory = 12'h456.
- mem_req, result_req and entry_valid in the same cycle -> S_MEM wins. After dwell, src_sel = 1 showing the new result; a following entry_valid returns src_sel to 0.
- mem_req again on the 3rd dwell cycle -> dwell restarts, busy = 1 for 4 more cycles. rst asserted mid-dwell -> all outputs return to reset values the next cycle.
- With DISPLAY_OVF_BLINK_EN: result_req with result_ovf = 1 -> blank sequence 1,1,0,0,1,1 in S_RESULT. Without the macro -> blank stays 0.
